ddr_tx: RTL

DDR_TX -- requirements
Module: ddr_tx

---
 rtl/ddr_tx.sv | 93 +++++++++
 1 files changed

// File: rtl/ddr_tx.sv
// ddr_tx: serializes a parallel word into rising/falling-edge bit pairs for a parent output DDR
// Ports: CLK sole clock; RST sync active-high reset; CE clock enable (low holds everything);
//        DATA_IN/VALID/READY word handshake; Q1/Q2 rising/falling-edge bits;
//        FRAME high while Q1/Q2 carry word or parity bits; BUSY high when not idle.
// Option: define DDR_TX_PARITY_EN to append a parity pair (Q1 = ^word, Q2 = ~Q1) to each word.
module ddr_tx #(
    parameter int DATA_WIDTH = 16,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  VALID,
    output logic                  READY,
    output logic                  Q1,
    output logic                  Q2,
    output logic                  FRAME,
    output logic                  BUSY
);
    localparam int NP = DATA_WIDTH / 2;
    localparam int CW = $clog2(NP) + 1;
    localparam logic [CW-1:0] LAST = CW'(NP - 1);
`ifdef DDR_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par_q;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] sreg_q, src, sreg_d;
    logic [1:0]            pair_d;
    logic                  q1_q, q2_q, frame_q, last_data, final_cyc, accept;
    // The next pair comes straight from DATA_IN on accept so the first pair appears one cycle later.
    always_comb begin
        last_data = state_q == SHIFT && cnt_q == LAST;
`ifdef DDR_TX_PARITY_EN
        final_cyc = state_q == PARITY;
`else
        final_cyc = last_data;
`endif
        READY  = CE && (state_q == IDLE || final_cyc);
        accept = READY && VALID;
        src    = accept ? DATA_IN : sreg_q;
        pair_d = MSB_FIRST ? {src[DATA_WIDTH-1], src[DATA_WIDTH-2]} : {src[0], src[1]};
        sreg_d = MSB_FIRST ? src << 2 : src >> 2;
        Q1     = q1_q;
        Q2     = q2_q;
        FRAME  = frame_q;
        BUSY   = state_q != IDLE;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            q1_q    <= 1'b0;
            q2_q    <= 1'b0;
            frame_q <= 1'b0;
`ifdef DDR_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (CE) begin
            if (accept) begin
                state_q        <= SHIFT;
                cnt_q          <= '0;
                sreg_q         <= sreg_d;
                {q1_q, q2_q}   <= pair_d;
                frame_q        <= 1'b1;
`ifdef DDR_TX_PARITY_EN
                par_q          <= ^DATA_IN;
`endif
            end else if (state_q == SHIFT && !last_data) begin
                cnt_q          <= cnt_q + CW'(1);
                sreg_q         <= sreg_d;
                {q1_q, q2_q}   <= pair_d;
`ifdef DDR_TX_PARITY_EN
            end else if (last_data) begin
                state_q        <= PARITY;
                q1_q           <= par_q;
                q2_q           <= ~par_q;
`endif
            end else begin
                state_q        <= IDLE;
                cnt_q          <= '0;
                q1_q           <= 1'b0;
                q2_q           <= 1'b0;
                frame_q        <= 1'b0;
            end
        end
    end
endmodule
